regfile_sb_bypass: RTL and testbench

//  Parametrised ARM-pipeline register file, successor to the fixed 15x32 file.
//  Two async read ports with same-cycle write-back bypass; one write-back port.

---
 rtl/regfile_sb_bypass.sv | 109 ++++++++++
 tb/tb_regfile_sb_bypass.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb_bypass.sv
// Parametrised register file: two async read ports with write-back bypass, one write port,
// a per-register pending-write scoreboard and a post-reset walk that loads Data[i] = i.
module regfile_sb_bypass #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ZERO_IDX = 15,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              busy1,
  output logic              busy2,
  output logic              init_busy
);

  localparam int unsigned       NR     = NUM_REGS;
  localparam bit                POW2   = ((1 << ADDR_W) == NUM_REGS);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_data [NUM_REGS];
  logic [NUM_REGS-1:0] r_pending;
  logic              w_ready;
  logic [ADDR_W-1:0] w_src  [2];
  logic [DATA_W-1:0] w_rd   [2];
  logic              w_busy [2];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return POW2 || (32'(a) < NR);
  endfunction

  assign w_ready   = (r_state == S_READY);
  assign init_busy = ~w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_cnt == LAST_A) w_state_nxt = S_READY;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_INIT)
        r_data[r_cnt] <= DATA_W'(r_cnt);
      else if (wb_en && wb_dest != ZERO_A && in_range(wb_dest))
        r_data[wb_dest] <= wb_data;
    end
  end

  // Issue is tested before write-back so a same-cycle issue keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_ready) begin
      for (int unsigned r = 0; r < NR; r++) begin
        if (issue_en && issue_dest == ADDR_W'(r) && ADDR_W'(r) != ZERO_A)
          r_pending[r] <= 1'b1;
        else if (wb_en && wb_dest == ADDR_W'(r))
          r_pending[r] <= 1'b0;
      end
    end
  end

  assign w_src[0] = src1;
  assign w_src[1] = src2;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_rd[p]   = '0;
      w_busy[p] = 1'b0;
      if (w_src[p] != ZERO_A && in_range(w_src[p])) begin
        if (w_ready && wb_en && wb_dest == w_src[p])
          w_rd[p] = wb_data;
        else
          w_rd[p] = r_data[w_src[p]];
        w_busy[p] = w_ready && r_pending[w_src[p]] && !(wb_en && wb_dest == w_src[p]);
      end
    end
  end

  assign rd1   = w_rd[0];
  assign rd2   = w_rd[1];
  assign busy1 = w_busy[0];
  assign busy2 = w_busy[1];

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Directed bench for regfile_sb_bypass: init walk, bypass, zero register,
// scoreboard set/clear priority and reset during the walk.
module tb_regfile_sb_bypass;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src1, src2, wb_dest, issue_dest;
  logic [31:0] rd1, rd2, wb_data;
  logic        wb_en, issue_en, busy1, busy2, init_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_sb_bypass #(.DATA_W(32), .NUM_REGS(16), .ZERO_IDX(15)) dut (
    .clk(clk), .reset(reset),
    .src1(src1), .src2(src2), .rd1(rd1), .rd2(rd2),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .busy1(busy1), .busy2(busy2), .init_busy(init_busy)
  );

  typedef struct {
    logic [3:0]  s1, s2;
    logic        we;
    logic [3:0]  wd;
    logic [31:0] wv;
    logic        ie;
    logic [3:0]  id;
    logic [31:0] e1, e2;
    logic        eb1, eb2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] s1, input logic [3:0] s2,
                              input logic we, input logic [3:0] wd, input logic [31:0] wv,
                              input logic ie, input logic [3:0] id,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic eb1, input logic eb2);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.we = we; v.wd = wd; v.wv = wv;
    v.ie = ie; v.id = id; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_en = 1'b0; wb_dest = '0; wb_data = '0;
    issue_en = 1'b0; issue_dest = '0;
  endtask

  // Holds reset across one rising edge; returns at the falling edge where reset drops.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b0; src1 = '0; src2 = '0;
    idle_inputs();

    // First walk; write-back and issue are driven from cycle 5 on and must be ignored.
    do_reset();
    src1 = 4'd3; src2 = 4'd14;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 5) begin
        wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'h0000_AAAA;
        issue_en = 1'b1; issue_dest = 4'd3;
      end
      #1;
      chk($sformatf("walk1 init_busy k=%0d", k), {31'b0, init_busy}, 32'd1);
      if (k == 0) chk("walk1 busy1", {31'b0, busy1}, 32'd0);
      if (k >= 5) chk($sformatf("walk1 no bypass k=%0d", k), rd1, 32'd3);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("walk1 done init_busy", {31'b0, init_busy}, 32'd0);
    chk("walk1 rd1 src3", rd1, 32'd3);
    chk("walk1 rd2 src14", rd2, 32'd14);
    chk("walk1 busy1 src3", {31'b0, busy1}, 32'd0);

    //              s1 s2 we wd  wv          ie id  e1          e2        b1 b2
    vecs.push_back(mk(15,15,1,15,32'hDEAD,   0, 0, 32'h0,      32'h0,      0, 0));
    vecs.push_back(mk(15,15,0, 0,32'h0,      0, 0, 32'h0,      32'h0,      0, 0));
    vecs.push_back(mk( 5, 6,1, 5,32'h1234,   0, 0, 32'h1234,   32'd6,      0, 0));
    vecs.push_back(mk( 5, 5,0, 0,32'h0,      0, 0, 32'h1234,   32'h1234,   0, 0));
    vecs.push_back(mk( 0, 7,0, 0,32'h0,      1, 7, 32'd0,      32'd7,      0, 0));
    vecs.push_back(mk( 7, 7,0, 0,32'h0,      0, 0, 32'd7,      32'd7,      1, 1));
    vecs.push_back(mk( 0, 7,1, 7,32'h7777,   0, 0, 32'd0,      32'h7777,   0, 0));
    vecs.push_back(mk( 7, 7,0, 0,32'h0,      0, 0, 32'h7777,   32'h7777,   0, 0));
    vecs.push_back(mk( 4, 2,0, 0,32'h0,      1, 4, 32'd4,      32'd2,      0, 0));
    vecs.push_back(mk( 4, 2,1, 4,32'h4444,   1, 4, 32'h4444,   32'd2,      0, 0));
    vecs.push_back(mk( 4, 4,0, 0,32'h0,      0, 0, 32'h4444,   32'h4444,   1, 1));
    vecs.push_back(mk( 4, 1,1, 4,32'h5555,   0, 0, 32'h5555,   32'd1,      0, 0));
    vecs.push_back(mk( 4, 4,0, 0,32'h0,      0, 0, 32'h5555,   32'h5555,   0, 0));
    vecs.push_back(mk(15, 0,0, 0,32'h0,      1,15, 32'h0,      32'd0,      0, 0));
    vecs.push_back(mk(15,15,1,15,32'h1,      0, 0, 32'h0,      32'h0,      0, 0));
    vecs.push_back(mk( 9, 8,1, 9,32'h99,     0, 0, 32'h99,     32'd8,      0, 0));
    vecs.push_back(mk( 9, 9,0, 0,32'h0,      0, 0, 32'h99,     32'h99,     0, 0));
    vecs.push_back(mk( 2, 3,1, 2,32'hFF,     1,12, 32'hFF,     32'd3,      0, 0));
    vecs.push_back(mk(12, 2,0, 0,32'h0,      0, 0, 32'd12,     32'hFF,     1, 0));
    vecs.push_back(mk( 1,12,1, 1,32'h11,     0, 0, 32'h11,     32'd12,     0, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      src1 = vecs[i].s1; src2 = vecs[i].s2;
      wb_en = vecs[i].we; wb_dest = vecs[i].wd; wb_data = vecs[i].wv;
      issue_en = vecs[i].ie; issue_dest = vecs[i].id;
      #1;
      chk($sformatf("vec%0d rd1", i), rd1, vecs[i].e1);
      chk($sformatf("vec%0d rd2", i), rd2, vecs[i].e2);
      chk($sformatf("vec%0d busy1", i), {31'b0, busy1}, {31'b0, vecs[i].eb1});
      chk($sformatf("vec%0d busy2", i), {31'b0, busy2}, {31'b0, vecs[i].eb2});
      chk($sformatf("vec%0d init_busy", i), {31'b0, init_busy}, 32'd0);
    end

    // Reset mid-walk: Data[2]=0xFF and pending[12]=1 from the READY phase above.
    do_reset();
    src1 = 4'd2; src2 = 4'd12;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) begin
        wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'h0000_ABCD;
      end else begin
        idle_inputs();
      end
      #1;
      if (k == 0) chk("walk2 busy2 cleared", {31'b0, busy2}, 32'd0);
      if (k == 2) chk("walk2 Data2 still old", rd1, 32'hFF);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    cnt = 0;
    while (init_busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("walk3 init cycles", cnt, 32'd16);
    chk("walk3 rd1 Data2", rd1, 32'd2);
    chk("walk3 rd2 Data12", rd2, 32'd12);
    chk("walk3 busy1", {31'b0, busy1}, 32'd0);
    chk("walk3 busy2", {31'b0, busy2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
